// File: rtl/fnd_scan_bcd_ctrl.sv
// Multi-digit 7-segment scan controller with sequential double-dabble.
// Accepts a binary value, converts it to BCD and multiplexes it onto the digits.
module fnd_scan_bcd_ctrl #(
  parameter int DIGITS   = 4,
  parameter int BIN_W    = 14,
  parameter int SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [BIN_W-1:0]  bin_in,
  input  logic              bin_valid,
  output logic              bin_ready,
  output logic              busy,
  output logic              ovf,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp_in,
  output logic [7:0]        seg_out,
  output logic [DIGITS-1:0] an_out
);

  localparam int BW = DIGITS * 4;
  localparam int SW = BW + BIN_W;
  localparam int CW = $clog2(BIN_W + 1);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [63:0] pow10m1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] MAXV = pow10m1(DIGITS);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD
  } state_t;

  state_t          state;
  logic [SW-1:0]   sr;
  logic [SW-1:0]   sr_adj;
  logic [CW-1:0]   cnt;
  logic            ovf_pend;
  logic [BW-1:0]   disp;
  logic [PW-1:0]   presc;
  logic [IW-1:0]   idx;
  logic [3:0]      nib;
  logic            blank;
  logic [6:0]      pat;

  // add-3 correction on every BCD nibble before the shift
  always_comb begin
    sr_adj = sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr[BIN_W+4*i +: 4] >= 4'd5)
        sr_adj[BIN_W+4*i +: 4] = sr[BIN_W+4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      ovf_pend  <= 1'b0;
      disp      <= '0;
      ovf       <= 1'b0;
      bin_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bin_valid) begin
            sr        <= {{BW{1'b0}}, bin_in};
            cnt       <= '0;
            ovf_pend  <= 64'(bin_in) > MAXV;
            state     <= CONV;
            bin_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        CONV: begin
          sr  <= {sr_adj[SW-2:0], 1'b0};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(BIN_W - 1)) state <= LOAD;
        end
        LOAD: begin
          disp      <= sr[SW-1 -: BW];
          ovf       <= ovf_pend;
          state     <= IDLE;
          bin_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_comb begin
    nib   = disp[{idx, 2'b00} +: 4];
    // a digit is leading-zero when it and every digit above it are zero
    blank = blank_lz && (idx != '0) &&
            ((disp >> {idx, 2'b00}) == '0);
    unique case (nib)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = 7'h7F;
    endcase
    if (ovf)        pat = 7'h3F;
    else if (blank) pat = 7'h7F;
    seg_out = {~dp_in[idx], pat};
    an_out  = ~(DIGITS'(1) << idx);
  end

endmodule

// File: tb/tb_fnd_scan_bcd_ctrl.sv
// Scoreboard bench for fnd_scan_bcd_ctrl (DIGITS=4, BIN_W=14, SCAN_DIV=4).
// Loads push expected digit patterns; a monitor checks them after each update.
module tb_fnd_scan_bcd_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [13:0] bin_in;
  logic        bin_valid;
  logic        bin_ready;
  logic        busy;
  logic        ovf;
  logic        blank_lz;
  logic [3:0]  dp_in;
  logic [7:0]  seg_out;
  logic [3:0]  an_out;

  typedef struct {
    logic        ovf;
    logic [31:0] seg;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   mon_done = 0;

  fnd_scan_bcd_ctrl #(
    .DIGITS(4),
    .BIN_W(14),
    .SCAN_DIV(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bin_in(bin_in),
    .bin_valid(bin_valid),
    .bin_ready(bin_ready),
    .busy(busy),
    .ovf(ovf),
    .blank_lz(blank_lz),
    .dp_in(dp_in),
    .seg_out(seg_out),
    .an_out(an_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // monitor: on every display update compare ovf and all four digits
  initial begin
    logic       prev;
    logic [3:0] want;
    exp_t       e;
    int         n;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev = 1'b0;
        continue;
      end
      if (prev && !busy) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_update actual=1 required=0");
        end else begin
          e = q.pop_front();
          check("ovf", 32'(ovf), 32'(e.ovf));
          for (int d = 0; d < 4; d++) begin
            want = ~(4'b0001 << d);
            n = 0;
            while (an_out !== want && n < 40) begin
              @(negedge clk);
              n++;
            end
            if (n >= 40) begin
              checks++;
              failures++;
              $display("FAIL scan_timeout an=%b required=%b", an_out, want);
            end else begin
              check($sformatf("seg%0d", d), 32'(seg_out),
                    32'(e.seg[8*d +: 8]));
            end
          end
        end
        mon_done++;
      end
      prev = busy;
    end
  end

  task automatic wait_update(input int start);
    int n;
    n = 0;
    while (mon_done == start && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (mon_done == start) begin
      checks++;
      failures++;
      $display("FAIL update_timeout actual=none required=update");
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bin_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic load(input logic [13:0] v, input logic bl,
                      input logic [3:0] dp, input logic ov,
                      input logic [31:0] seg, output int bcnt);
    int start;
    int n;
    blank_lz = bl;
    dp_in    = dp;
    wait_ready();
    q.push_back(exp_t'{ov, seg});
    start     = mon_done;
    bin_in    = v;
    bin_valid = 1'b1;
    @(posedge clk);
    #1;
    bin_valid = 1'b0;
    bcnt = 0;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (!busy) break;
      bcnt++;
      n++;
    end
    wait_update(start);
  endtask

  initial begin
    int bc;
    int start;
    reset_n   = 1'b0;
    bin_in    = '0;
    bin_valid = 1'b0;
    blank_lz  = 1'b0;
    dp_in     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bin_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_an", 32'(an_out), 32'hE);
    check("rst_seg", 32'(seg_out), 32'hC0);

    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      @(negedge clk);
      check($sformatf("scan_an_c%0d", c), 32'(an_out),
            32'(4'(~(4'b0001 << ((c / 4) % 4)))));
      check($sformatf("scan_seg_c%0d", c), 32'(seg_out), 32'hC0);
    end
    @(posedge clk);
    #1;

    load(14'd1234, 1'b0, 4'b0000, 1'b0, 32'hF9A4B099, bc);
    check("busy_cycles", 32'(bc), 32'd15);
    load(14'd9999, 1'b0, 4'b0000, 1'b0, 32'h90909090, bc);
    load(14'd10000, 1'b0, 4'b0000, 1'b1, 32'hBFBFBFBF, bc);
    load(14'd5, 1'b0, 4'b0000, 1'b0, 32'hC0C0C092, bc);
    load(14'd16383, 1'b0, 4'b0000, 1'b1, 32'hBFBFBFBF, bc);
    load(14'd7, 1'b1, 4'b0000, 1'b0, 32'hFFFFFFF8, bc);
    load(14'd0, 1'b1, 4'b0000, 1'b0, 32'hFFFFFFC0, bc);
    load(14'd1005, 1'b1, 4'b0000, 1'b0, 32'hF9C0C092, bc);
    load(14'd30, 1'b1, 4'b0000, 1'b0, 32'hFFFFB0C0, bc);

    // second bin_valid during CONV must be dropped
    blank_lz = 1'b0;
    dp_in    = 4'b0000;
    wait_ready();
    q.push_back(exp_t'{1'b0, 32'hF9A4B099});
    start     = mon_done;
    bin_in    = 14'd1234;
    bin_valid = 1'b1;
    @(posedge clk);
    #1;
    bin_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    bin_in    = 14'd42;
    bin_valid = 1'b1;
    @(posedge clk);
    #1;
    bin_valid = 1'b0;
    wait_update(start);
    repeat (5) @(negedge clk);
    check("no_queue_busy", 32'(busy), 32'd0);

    load(14'd1234, 1'b0, 4'b0100, 1'b0, 32'hF924B099, bc);
    load(14'd10000, 1'b0, 4'b0100, 1'b1, 32'hBF3FBFBF, bc);

    // reset pulse mid-conversion
    dp_in = 4'b0000;
    wait_ready();
    bin_in    = 14'd42;
    bin_valid = 1'b1;
    @(posedge clk);
    #1;
    bin_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", 32'(bin_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    check("mid_rst_an", 32'(an_out), 32'hE);
    check("mid_rst_seg", 32'(seg_out), 32'hC0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int d = 1; d < 4; d++) begin
      int n;
      n = 0;
      while (an_out !== 4'(~(4'b0001 << d)) && n < 40) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("mid_rst_seg%0d", d), 32'(seg_out), 32'hC0);
    end
    repeat (20) @(negedge clk);
    check("mid_rst_stay_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
